// File: rtl/mem_port_ctrl_pkg.sv
// Shared types and helpers for the memory port controller.
// Holds the FSM state type, the access-size encodings and the alignment rule.
package mem_port_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StFin  = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Legal, naturally aligned request; size 2'b11 is reserved.
    function automatic logic req_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Memory-side request/response bus of the port controller.
// master = controller, slave = memory model or memory subsystem.
interface mem_port_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) ();

    logic              MOV;
    logic              MEM_RW;
    logic [1:0]        MEM_SIZE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              MFC;
    logic [DATA_W-1:0] MEM_RDATA;

    modport master (
        output MOV, MEM_RW, MEM_SIZE, MEM_ADDR, MEM_WDATA,
        input  MFC, MEM_RDATA
    );

    modport slave (
        input  MOV, MEM_RW, MEM_SIZE, MEM_ADDR, MEM_WDATA,
        output MFC, MEM_RDATA
    );

endinterface

// File: rtl/ld_reg.sv
// Generic load-enabled register with asynchronous active-low clear.
module ld_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] val_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            val_q <= '0;
        end else if (ld_i) begin
            val_q <= d_i;
        end
    end

    assign q_o = val_q;

endmodule

// File: rtl/mem_port_ctrl.sv
// MAR/MDR memory port controller: issues one aligned request at a time, waits for MFC
// with a bounded timeout, and writes size/sign-adjusted read data back into MDR.
module mem_port_ctrl
    import mem_port_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TMO    = 15
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              MARLd,
    input  logic [ADDR_W-1:0] MAR_D,
    input  logic              MDRLd,
    input  logic [DATA_W-1:0] MDR_D,
    input  logic              Start,
    input  logic              RW,
    input  logic [1:0]        Size,
    input  logic              Sext,
    output logic [ADDR_W-1:0] MAR_Q,
    output logic [DATA_W-1:0] MDR_Q,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    mem_port_ctrl_if.master   mem
);

    localparam logic [7:0] TmoLast = 8'(TMO - 1);

    state_e            state_q;
    logic [7:0]        wait_q;
    logic              mov_q, rw_q, sext_q, done_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              idle, rd_done, mar_ld, mdr_ld;
    logic [DATA_W-1:0] mdr_d, rd_ext;

    assign idle    = (state_q == StIdle);
    assign rd_done = (state_q == StReq) & mem.MFC & rw_q;
    assign mar_ld  = idle & MARLd;
    assign mdr_ld  = (idle & MDRLd) | rd_done;
    assign mdr_d   = rd_done ? rd_ext : MDR_D;

    always_comb begin
        rd_ext = '0;
        case (size_q)
            SZ_BYTE: begin
                if (sext_q) rd_ext = DATA_W'($signed(mem.MEM_RDATA[7:0]));
                else        rd_ext = DATA_W'(mem.MEM_RDATA[7:0]);
            end
            SZ_HALF: begin
                if (sext_q) rd_ext = DATA_W'($signed(mem.MEM_RDATA[15:0]));
                else        rd_ext = DATA_W'(mem.MEM_RDATA[15:0]);
            end
            default: begin
                if (sext_q) rd_ext = DATA_W'($signed(mem.MEM_RDATA[31:0]));
                else        rd_ext = DATA_W'(mem.MEM_RDATA[31:0]);
            end
        endcase
    end

    ld_reg #(.W(ADDR_W)) u_mar (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .ld_i   (mar_ld),
        .d_i    (MAR_D),
        .q_o    (MAR_Q)
    );

    ld_reg #(.W(DATA_W)) u_mdr (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .ld_i   (mdr_ld),
        .d_i    (mdr_d),
        .q_o    (MDR_Q)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            wait_q  <= '0;
            mov_q   <= 1'b0;
            rw_q    <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (Start) begin
                        if (req_aligned(Size, MAR_Q[1:0])) begin
                            state_q <= StReq;
                            mov_q   <= 1'b1;
                            rw_q    <= RW;
                            size_q  <= Size;
                            sext_q  <= Sext;
                            addr_q  <= MAR_Q;
                            wdata_q <= MDR_Q;
                            wait_q  <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    // MFC wins over a timeout landing in the same cycle.
                    if (mem.MFC) begin
                        state_q <= StFin;
                        mov_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (wait_q == TmoLast) begin
                        state_q <= StIdle;
                        mov_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StFin: state_q <= StIdle;
                default: begin
                    state_q <= StIdle;
                    mov_q   <= 1'b0;
                end
            endcase
        end
    end

    assign Busy          = ~idle;
    assign Done          = done_q;
    assign Err           = err_q;
    assign mem.MOV       = mov_q;
    assign mem.MEM_RW    = rw_q;
    assign mem.MEM_SIZE  = size_q;
    assign mem.MEM_ADDR  = addr_q;
    assign mem.MEM_WDATA = wdata_q;

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning MAR and memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning MDR and memory data width (multiple of 32).
REQ-003 SHALL have parameter TMO, default 15, meaning max wait cycles for MFC before error (1..255).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-005 Ports, in this order:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  async active-low reset.
- MARLd  in  1  load MAR from MAR_D.
- MAR_D  in  ADDR_W  MAR load data.
- MDRLd  in  1  load MDR from MDR_D.
- MDR_D  in  DATA_W  MDR load data.
- Start  in  1  begin memory transaction.
- RW  in  1  1 = read, 0 = write.
- Size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- Sext  in  1  sign-extend read data.
- MAR_Q  out  ADDR_W  MAR contents.
- MDR_Q  out  DATA_W  MDR contents.
- Busy  out  1  transaction in progress.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  one-cycle error pulse.
- MOV  out  1  memory operation valid.
- MEM_RW, MEM_SIZE, MEM_ADDR, MEM_WDATA  out  1/2/ADDR_W/DATA_W  registered request fields.
- MFC  in  1  memory function complete.
- MEM_RDATA  in  DATA_W  read data, valid with MFC.

Function
REQ-006 SHALL implement FSM states IDLE, REQ, FIN; Busy = (state != IDLE).
REQ-007 In IDLE, MARLd/MDRLd SHALL load MAR/MDR at the next rising edge; both may load in the same cycle.
REQ-008 In REQ or FIN, MARLd, MDRLd and Start SHALL be ignored.
REQ-009 Start in IDLE with a legal aligned request SHALL capture RW, Size, MAR, MDR into MEM_* and enter REQ; MOV SHALL be high from the next cycle.
REQ-010 Alignment: halfword requires MAR[0]=0; word requires MAR[1:0]=00; Size=11 is illegal.
REQ-011 Start in IDLE with an illegal or misaligned request SHALL pulse Err the next cycle, stay in IDLE, never assert MOV, and leave MAR/MDR unchanged.
REQ-012 In REQ, MOV and MEM_* SHALL stay stable until MFC is sampled high.
REQ-013 MFC in REQ SHALL drop MOV on the next edge and enter FIN. On a read, MDR SHALL take MEM_RDATA low 8/16/32 bits, zero-extended, or sign-extended when Sext=1. On a write, MDR SHALL be unchanged.
REQ-014 FIN SHALL last exactly one cycle with Done=1, then return to IDLE; Start-to-Done minimum latency SHALL be 3 cycles (MFC in the first REQ cycle).
REQ-015 A wait counter SHALL count REQ cycles without MFC. When it reaches TMO, the block SHALL drop MOV, pulse Err for one cycle, return to IDLE, and leave MDR unchanged.
REQ-016 MFC sampled in the same cycle the counter reaches TMO SHALL count as success (Done, not Err).
REQ-017 MFC while in IDLE or FIN SHALL be ignored.
REQ-018 Done and Err SHALL never be high in the same cycle.

Reset
REQ-019 RST_N low SHALL asynchronously force state IDLE and clear all of the following to 0: MAR, MDR, MEM_*, the counter, MOV, Busy, Done and Err.
REQ-020 Reset during REQ SHALL abort the transaction: MOV low immediately, no Done, no Err.
REQ-021 After RST_N deasserts, the first edge SHALL operate normally.

Structure
REQ-022 A shared package SHALL hold the state enum, the Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the alignment-check function.
REQ-023 A generic load-enabled register sub-module ld_reg #(W) with async active-low reset SHALL be instantiated for MAR and MDR.

Verification
REQ-024 Write, word: MAR=0x10, MDR=0xDEADBEEF, Start, RW=0; MFC after 2 cycles -> MOV held 3 cycles, MEM_ADDR=0x10, MEM_WDATA=0xDEADBEEF, Done pulses once, MDR unchanged.
REQ-025 Read byte, Sext=1: MAR=0x03, MEM_RDATA=0x000000F0 -> MDR=0xFFFFFFF0. Repeat with Sext=0 -> MDR=0x000000F0.
REQ-026 Misalignment: word at MAR=0x02, and halfword at 0x01 -> Err next cycle, MOV never high, Busy stays 0.
REQ-027 Timeout: TMO=4, no MFC -> MOV high 4 cycles, then Err pulse, IDLE. MFC exactly on cycle 4 -> Done, not Err.
REQ-028 Busy blocking: MARLd=1 with MAR_D=0x55 and Start during REQ -> MAR unchanged, no second transaction.
REQ-029 Reset mid-REQ: RST_N low in cycle 2 of REQ -> MOV, MAR, MDR all 0 immediately; Done and Err stay 0.
